// File: rtl/final_top.sv
// Streaming sample processor: power-of-two moving average followed by a
// hysteresis slicer that recovers a bit stream and flags every transition.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   din        : signed input sample
//   din_valid  : din carries a new sample this cycle
//   avg_out    : signed moving average of the last TAPS accepted samples
//   avg_valid  : strobe, avg_out updated this edge with a full window
//   bit_out    : hysteresis-sliced bit
//   edge_pulse : strobe, bit_out changed this edge
module final_top #(
   parameter int WIDTH     = 12,
   parameter int LOG2_TAPS = 3,
   parameter int THRESH_HI = 100,
   parameter int THRESH_LO = 50
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic [WIDTH-1:0] avg_out,
   output logic             avg_valid,
   output logic             bit_out,
   output logic             edge_pulse
);

   localparam int TAPS = 1 << LOG2_TAPS;
   localparam int SW   = WIDTH + LOG2_TAPS;
   localparam int FW   = LOG2_TAPS + 1;

   localparam logic signed [WIDTH-1:0] TH_HI = WIDTH'(THRESH_HI);
   localparam logic signed [WIDTH-1:0] TH_LO = WIDTH'(THRESH_LO);
   localparam logic [FW-1:0]           FULL  = FW'(TAPS);

   if (THRESH_LO > THRESH_HI) begin : g_bad_thresh
      $fatal(1, "final_top: THRESH_LO must not exceed THRESH_HI");
   end
   if (LOG2_TAPS < 1 || LOG2_TAPS > 6) begin : g_bad_taps
      $fatal(1, "final_top: LOG2_TAPS must be in 1..6");
   end

   // dly_q[0] is the newest sample, dly_q[TAPS-1] the oldest
   logic [WIDTH-1:0]        dly_q [TAPS];
   logic signed [SW-1:0]    sum_q, sum_d;
   logic [FW-1:0]           fill_q, fill_d;
   logic signed [WIDTH-1:0] avg_q, avg_d;
   logic                    avg_valid_q, avg_valid_d;
   logic                    bit_q, bit_d;
   logic                    edge_q, edge_d;

   logic signed [SW-1:0]    din_ext, old_ext, sum_sh;

   always_comb begin
      din_ext = {{LOG2_TAPS{din[WIDTH-1]}}, din};
      old_ext = {{LOG2_TAPS{dly_q[TAPS-1][WIDTH-1]}}, dly_q[TAPS-1]};
      // The sum of TAPS WIDTH-bit samples always fits in SW bits.
      sum_d   = sum_q + din_ext - old_ext;
      // Arithmetic shift floors toward minus infinity; result fits WIDTH.
      sum_sh  = sum_d >>> LOG2_TAPS;
      avg_d   = sum_sh[WIDTH-1:0];
      fill_d  = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
   end

   always_comb begin
      bit_d = bit_q;
      if (din_valid) begin
         if (avg_d > TH_HI) begin
            bit_d = 1'b1;
         end else if (avg_d < TH_LO) begin
            bit_d = 1'b0;
         end
      end
      avg_valid_d = din_valid && (fill_d == FULL);
      edge_d      = din_valid && (bit_d != bit_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) begin
            dly_q[i] <= '0;
         end
         sum_q       <= '0;
         fill_q      <= '0;
         avg_q       <= '0;
         avg_valid_q <= 1'b0;
         bit_q       <= 1'b0;
         edge_q      <= 1'b0;
      end else begin
         avg_valid_q <= avg_valid_d;
         edge_q      <= edge_d;
         if (din_valid) begin
            dly_q[0] <= din;
            for (int i = 1; i < TAPS; i++) begin
               dly_q[i] <= dly_q[i-1];
            end
            sum_q  <= sum_d;
            fill_q <= fill_d;
            avg_q  <= avg_d;
            bit_q  <= bit_d;
         end
      end
   end

   assign avg_out    = avg_q;
   assign avg_valid  = avg_valid_q;
   assign bit_out    = bit_q;
   assign edge_pulse = edge_q;

endmodule

// File: tb/tb_final_top.sv
// Self-checking bench for final_top: a reference model pushes expected
// outputs to a scoreboard as stimulus is driven; tasks pop and compare.
module tb_final_top;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] din;
   logic        din_valid;
   logic [11:0] avg_out;
   logic        avg_valid;
   logic        bit_out;
   logic        edge_pulse;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [11:0] avg;
      logic        v;
      logic        b;
      logic        e;
   } exp_t;

   exp_t sb[$];
   exp_t ex;

   int  mdly [8];
   int  msum;
   int  mfill;
   int  mavg;
   bit  mbit;

   final_top #(
      .WIDTH(12), .LOG2_TAPS(3), .THRESH_HI(100), .THRESH_LO(50)
   ) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
      .avg_out(avg_out), .avg_valid(avg_valid),
      .bit_out(bit_out), .edge_pulse(edge_pulse)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) mdly[i] = 0;
      msum  = 0;
      mfill = 0;
      mavg  = 0;
      mbit  = 0;
   endfunction

   function automatic exp_t model_step(bit v, int d);
      exp_t r;
      bit   nb;
      int   a;
      r.v = 1'b0;
      r.e = 1'b0;
      if (v) begin
         msum = msum + d - mdly[7];
         for (int i = 7; i > 0; i--) mdly[i] = mdly[i-1];
         mdly[0] = d;
         a = msum >>> 3;
         mavg = a;
         if (mfill < 8) mfill++;
         nb = mbit;
         if (a > 100) nb = 1;
         else if (a < 50) nb = 0;
         r.e  = (nb != mbit);
         mbit = nb;
         r.v  = (mfill == 8);
      end
      r.avg = 12'(mavg);
      r.b   = mbit;
      return r;
   endfunction

   // drive one cycle; returns #1 after the active edge
   task automatic step(bit v, int d);
      din       = 12'(d);
      din_valid = v;
      sb.push_back(model_step(v, d));
      @(posedge clk);
      #1;
   endtask

   // assert reset mid-cycle, then release it away from the edge
   task automatic do_reset();
      #3;
      rst_n = 1'b0;
      din_valid = 1'b0;
      model_reset();
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      din = '0;
      din_valid = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1, 300);
         void'(sb.pop_front());
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({avg_out, avg_valid, bit_out, edge_pulse} !== 15'd0) begin
         errors++;
         $display("FAIL async_reset: got avg=%h v=%b b=%b e=%b want all 0",
                  avg_out, avg_valid, bit_out, edge_pulse);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(0, 0);
         ex = sb.pop_front();
         checks++;
         if ({avg_out, avg_valid, bit_out, edge_pulse} !== 15'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got avg=%h v=%b b=%b e=%b want 0",
                     avg_out, avg_valid, bit_out, edge_pulse);
         end
      end
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 8; i++) begin
         step(1, 80);
         ex = sb.pop_front();
         checks++;
         if (avg_out !== ex.avg || avg_valid !== ex.v ||
             bit_out !== ex.b || edge_pulse !== ex.e) begin
            errors++;
            $display("FAIL fill_%0d: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                     avg_out, avg_valid, bit_out, edge_pulse,
                     ex.avg, ex.v, ex.b, ex.e);
         end
         if (i == 1 || i == 7 || i == 8) begin
            checks++;
            if (avg_out !== 12'(i * 10) || avg_valid !== (i == 8) ||
                bit_out !== 1'b0) begin
               errors++;
               $display("FAIL fill_const_%0d: got avg=%0d v=%b b=%b want %0d/%b/0",
                        i, avg_out, avg_valid, bit_out, i * 10, i == 8);
            end
         end
      end
   endtask

   task automatic test_hysteresis();
      int want_avg [9] = '{95, 110, 100, 90, 80, 70, 60, 50, 25};
      bit want_bit [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
      bit want_e   [9] = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
      for (int i = 0; i < 9; i++) begin
         step(1, (i < 2) ? 200 : 0);
         ex = sb.pop_front();
         checks++;
         if (avg_out !== ex.avg || avg_valid !== ex.v ||
             bit_out !== ex.b || edge_pulse !== ex.e) begin
            errors++;
            $display("FAIL hyst_sb_%0d: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                     avg_out, avg_valid, bit_out, edge_pulse,
                     ex.avg, ex.v, ex.b, ex.e);
         end
         checks++;
         if (avg_out !== 12'(want_avg[i]) || bit_out !== want_bit[i] ||
             edge_pulse !== want_e[i]) begin
            errors++;
            $display("FAIL hyst_const_%0d: got avg=%0d b=%b e=%b want %0d/%b/%b",
                     i, avg_out, bit_out, edge_pulse,
                     want_avg[i], want_bit[i], want_e[i]);
         end
      end
   endtask

   task automatic test_negative();
      int vals [3] = '{-8, -1, 7};
      int reps [3] = '{8, 1, 1};
      logic [11:0] want [3] = '{12'hFF8, 12'hFFF, 12'h000};
      for (int k = 0; k < 3; k++) begin
         do_reset();
         for (int i = 0; i < reps[k]; i++) begin
            step(1, vals[k]);
            ex = sb.pop_front();
            checks++;
            if (avg_out !== ex.avg || avg_valid !== ex.v ||
                bit_out !== ex.b || edge_pulse !== ex.e) begin
               errors++;
               $display("FAIL neg_sb_%0d_%0d: got %h/%b/%b/%b want %h/%b/%b/%b",
                        k, i, avg_out, avg_valid, bit_out, edge_pulse,
                        ex.avg, ex.v, ex.b, ex.e);
            end
         end
         checks++;
         if (avg_out !== want[k]) begin
            errors++;
            $display("FAIL neg_const_%0d: got avg=%h want %h", k, avg_out, want[k]);
         end
      end
   endtask

   task automatic test_gaps();
      logic [11:0] prev;
      int nvalid = 0;
      do_reset();
      for (int c = 0; c < 18; c++) begin
         prev = avg_out;
         step(c % 2 == 0, 40);
         if (c % 2 == 0) nvalid++;
         ex = sb.pop_front();
         checks++;
         if (avg_out !== ex.avg || avg_valid !== ex.v ||
             bit_out !== ex.b || edge_pulse !== ex.e) begin
            errors++;
            $display("FAIL gaps_sb_%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c,
                     avg_out, avg_valid, bit_out, edge_pulse,
                     ex.avg, ex.v, ex.b, ex.e);
         end
         if (c % 2 == 1) begin
            checks++;
            if (avg_valid !== 1'b0 || avg_out !== prev) begin
               errors++;
               $display("FAIL gaps_idle_%0d: got avg=%0d v=%b want avg=%0d v=0",
                        c, avg_out, avg_valid, prev);
            end
         end else if (nvalid == 7 || nvalid == 8) begin
            checks++;
            if (avg_valid !== (nvalid == 8) || avg_out !== 12'(nvalid * 5)) begin
               errors++;
               $display("FAIL gaps_fill_%0d: got avg=%0d v=%b want %0d/%b",
                        nvalid, avg_out, avg_valid, nvalid * 5, nvalid == 8);
            end
         end
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(1, 200);
         ex = sb.pop_front();
         checks++;
         if (avg_out !== ex.avg || avg_valid !== ex.v ||
             bit_out !== ex.b || edge_pulse !== ex.e) begin
            errors++;
            $display("FAIL mid_sb_%0d: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                     avg_out, avg_valid, bit_out, edge_pulse,
                     ex.avg, ex.v, ex.b, ex.e);
         end
      end
      checks++;
      if (bit_out !== 1'b1 || avg_out !== 12'd200 || avg_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_full: got avg=%0d v=%b b=%b want 200/1/1",
                  avg_out, avg_valid, bit_out);
      end
      #3;
      rst_n = 1'b0;
      din_valid = 1'b0;
      #1;
      checks++;
      if ({avg_out, avg_valid, bit_out, edge_pulse} !== 15'd0) begin
         errors++;
         $display("FAIL mid_reset: got avg=%h v=%b b=%b e=%b want all 0",
                  avg_out, avg_valid, bit_out, edge_pulse);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1, 80);
      ex = sb.pop_front();
      checks++;
      if (avg_out !== 12'd10 || avg_valid !== 1'b0 || bit_out !== 1'b0 ||
          avg_out !== ex.avg) begin
         errors++;
         $display("FAIL mid_refill: got avg=%0d v=%b b=%b want 10/0/0",
                  avg_out, avg_valid, bit_out);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_hysteresis();
      test_negative();
      test_gaps();
      test_reset_midstream();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
